// File: rtl/counter_timeout_scheduler.sv
// Round-robin arbiter that lends one shared down-counter to several requesters
// and returns a one-cycle done pulse to the owner when its interval expires.
module counter_timeout_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_config,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   cnt_load,
    output logic [1:0]             cnt_load_config,
    output logic                   cnt_reset_counter,
    input  logic                   cnt_expire
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [1:0]      cfg_reg;
    logic [ID_W-1:0] pick_id;
    logic            pick_valid;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] next_id;
    logic            owner_req;
    int              idx;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        idx        = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx  = (int'(rr_ptr) + off) % NUM_REQ;
            cand = ID_W'(idx);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign next_id         = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign owner_req       = req[grant_id];
    assign cnt_load_config = cfg_reg;

    // ARM never looks at cnt_expire: it can still be high from the previous interval.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_id          <= '0;
            cfg_reg           <= '0;
            done              <= '0;
            busy              <= 1'b0;
            cnt_load          <= 1'b0;
            cnt_reset_counter <= 1'b0;
        end else begin
            done              <= '0;
            cnt_load          <= 1'b0;
            cnt_reset_counter <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_id;
                        cfg_reg  <= req_config[{pick_id, 1'b0} +: 2];
                        cnt_load <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (!owner_req) begin
                        rr_ptr <= next_id;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt_reset_counter <= 1'b1;
                        state             <= ARM;
                    end
                end
                ARM: begin
                    if (!owner_req) begin
                        rr_ptr <= next_id;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!owner_req) begin
                        rr_ptr <= next_id;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt_expire) begin
                        done[grant_id] <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= next_id;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_timeout_scheduler.sv
// Scoreboard bench for counter_timeout_scheduler with a scaled counter stub
// (reload 24/49/74/99); expected done pulses are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_counter_timeout_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [2*NUM_REQ-1:0] req_config = '0;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 cnt_load;
    logic [1:0]           cnt_load_config;
    logic                 cnt_reset_counter;
    logic                 cnt_expire;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    counter_timeout_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clock             (clock),
        .resetn            (resetn),
        .req               (req),
        .req_config        (req_config),
        .done              (done),
        .busy              (busy),
        .grant_id          (grant_id),
        .cnt_load          (cnt_load),
        .cnt_load_config   (cnt_load_config),
        .cnt_reset_counter (cnt_reset_counter),
        .cnt_expire        (cnt_expire)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Counter stub: latch config on load, reload and clear expire on reset_counter.
    logic [1:0] stub_cfg;
    int         stub_cnt;

    function automatic int reload(logic [1:0] c);
        return 24 + 25 * int'(c);
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stub_cfg   <= 2'd0;
            stub_cnt   <= 0;
            cnt_expire <= 1'b0;
        end else begin
            if (cnt_load) stub_cfg <= cnt_load_config;
            if (cnt_reset_counter) begin
                stub_cnt   <= reload(stub_cfg);
                cnt_expire <= 1'b0;
            end else if (stub_cnt == 0) begin
                cnt_expire <= 1'b1;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [2*NUM_REQ-1:0] cfg);
        req        = r;
        req_config = cfg;
    endtask

    task automatic expectDone(input logic [NUM_REQ-1:0] mask, input int at);
        exp_t e;
        e.mask = mask;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Monitor: every done pulse must match the next queued expectation exactly.
    always @(negedge clock) begin
        if (resetn && done != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: got %b expected none (cycle %0d)", done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (done !== mon_e.mask || cyc != mon_e.at) begin
                    errors++;
                    $display("[TB] FAIL done_pulse: got %b at cycle %0d expected %b at cycle %0d",
                             done, cyc, mon_e.mask, mon_e.at);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, c1, c3, c4, c6;

        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_load", 32'(cnt_load), 0);
        checkOutput("reset_rst_cnt", 32'(cnt_reset_counter), 0);
        checkOutput("reset_load_cfg", 32'(cnt_load_config), 0);
        checkOutput("reset_grant", 32'(grant_id), 0);
        resetn = 1'b1;

        // Single request, config 1 (R=49)
        @(negedge clock);
        c0 = cyc;
        applyStimulus(4'b0001, 8'h01);
        expectDone(4'b0001, c0 + 54);
        waitUntil(c0 + 1);
        checkOutput("t1_load", 32'(cnt_load), 1);
        checkOutput("t1_load_cfg", 32'(cnt_load_config), 1);
        checkOutput("t1_grant", 32'(grant_id), 0);
        checkOutput("t1_busy", 32'(busy), 1);
        waitUntil(c0 + 2);
        checkOutput("t1_arm", 32'(cnt_reset_counter), 1);
        checkOutput("t1_load_off", 32'(cnt_load), 0);
        waitUntil(c0 + 30);
        checkOutput("t1_grant_stable", 32'(grant_id), 0);
        waitUntil(c0 + 54);
        applyStimulus(4'b0000, 8'h00);
        waitUntil(c0 + 55);
        checkOutput("t1_idle_after", 32'(busy), 0);

        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // Round robin, all configs 0 (R=24): grant period R+6
        c1 = cyc;
        applyStimulus(4'b1111, 8'h00);
        for (int k = 0; k < 5; k++) expectDone(4'(1 << (k % 4)), c1 + 29 + 30 * k);
        for (int k = 0; k < 5; k++) begin
            waitUntil(c1 + 1 + 30 * k);
            checkOutput("t2_rr_grant", 32'(grant_id), 32'(k % 4));
            checkOutput("t2_rr_load", 32'(cnt_load), 1);
        end
        waitUntil(c1 + 149);
        applyStimulus(4'b0000, 8'h00);
        waitUntil(c1 + 151);
        checkOutput("t2_idle_after", 32'(busy), 0);

        // Abandon: requester 2 (config 3) drops 10 cycles into WAIT, 3 is pending
        c3 = cyc;
        applyStimulus(4'b1100, 8'h30);
        expectDone(4'b1000, c3 + 43);
        waitUntil(c3 + 1);
        checkOutput("t3_grant2", 32'(grant_id), 2);
        checkOutput("t3_cfg3", 32'(cnt_load_config), 3);
        waitUntil(c3 + 13);
        applyStimulus(4'b1000, 8'h30);
        waitUntil(c3 + 14);
        checkOutput("t3_abandon_idle", 32'(busy), 0);
        waitUntil(c3 + 15);
        checkOutput("t3_grant3", 32'(grant_id), 3);
        checkOutput("t3_load3", 32'(cnt_load), 1);
        checkOutput("t3_cfg0", 32'(cnt_load_config), 0);
        waitUntil(c3 + 43);
        applyStimulus(4'b0000, 8'h30);

        // Config change during WAIT has no effect
        waitUntil(c3 + 45);
        c4 = cyc;
        applyStimulus(4'b0010, 8'h00);
        expectDone(4'b0010, c4 + 29);
        waitUntil(c4 + 1);
        checkOutput("t4_grant1", 32'(grant_id), 1);
        checkOutput("t4_cfg0", 32'(cnt_load_config), 0);
        waitUntil(c4 + 10);
        applyStimulus(4'b0010, 8'hFF);

        // Immediate regrant while the counter still shows a stale expire
        waitUntil(c4 + 29);
        applyStimulus(4'b0001, 8'h00);
        expectDone(4'b0001, c4 + 59);
        waitUntil(c4 + 31);
        checkOutput("t5_grant0", 32'(grant_id), 0);
        checkOutput("t5_load", 32'(cnt_load), 1);
        waitUntil(c4 + 32);
        checkOutput("t5_arm", 32'(cnt_reset_counter), 1);
        checkOutput("t5_stale_expire", 32'(cnt_expire), 1);
        waitUntil(c4 + 33);
        checkOutput("t5_still_busy", 32'(busy), 1);
        waitUntil(c4 + 59);
        applyStimulus(4'b0000, 8'h00);

        // Asynchronous reset in the middle of WAIT
        waitUntil(c4 + 61);
        c6 = cyc;
        applyStimulus(4'b0010, 8'h00);
        waitUntil(c6 + 10);
        checkOutput("t6_busy_pre", 32'(busy), 1);
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 32'(busy), 0);
        checkOutput("t6_rst_load", 32'(cnt_load), 0);
        checkOutput("t6_rst_arm", 32'(cnt_reset_counter), 0);
        checkOutput("t6_rst_done", 32'(done), 0);
        checkOutput("t6_rst_grant", 32'(grant_id), 0);
        checkOutput("t6_rst_cfg", 32'(cnt_load_config), 0);
        applyStimulus(4'b0000, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        c6 = cyc;
        applyStimulus(4'b0101, 8'h00);
        expectDone(4'b0001, c6 + 29);
        expectDone(4'b0100, c6 + 59);
        waitUntil(c6 + 1);
        checkOutput("t6_grant0_ptr_reset", 32'(grant_id), 0);
        waitUntil(c6 + 29);
        applyStimulus(4'b0100, 8'h00);
        waitUntil(c6 + 31);
        checkOutput("t6_grant2", 32'(grant_id), 2);
        waitUntil(c6 + 59);
        applyStimulus(4'b0000, 8'h00);
        waitUntil(c6 + 65);
        checkOutput("final_busy", 32'(busy), 0);
        checkOutput("pending_done", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
